// File: rtl/gate_timing_ctrl.sv
// Per-channel gate sequencing and supervision: arm, wait for the gate to rise within a
// timeout, then check that it stays high for a minimum length. Error flags are sticky.
module gate_timing_ctrl #(
  parameter int N_CH  = 12,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_CH-1:0]  gate_in,
  input  logic [N_CH-1:0]  ch_enable,
  input  logic             arm,
  input  logic             clear,
  input  logic [CNT_W-1:0] timeout_val,
  input  logic [CNT_W-1:0] min_len_val,
  output logic [N_CH-1:0]  gate_active,
  output logic [N_CH-1:0]  gate_valid,
  output logic [N_CH-1:0]  err_timeout,
  output logic [N_CH-1:0]  err_short,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ON   = 2'd2,
    S_OK   = 2'd3
  } state_t;

  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]  err_to_q, err_to_d;
  logic [N_CH-1:0]  err_sh_q, err_sh_d;
  logic [N_CH-1:0]  set_to, set_sh;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= {CNT_W{1'b0}};
      end
      err_to_q <= {N_CH{1'b0}};
      err_sh_q <= {N_CH{1'b0}};
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      err_to_q <= err_to_d;
      err_sh_q <= err_sh_d;
    end
  end

  // Disable has priority over every transition; gate rise beats timeout in WAIT.
  always_comb begin
    set_to = {N_CH{1'b0}};
    set_sh = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (state_q[i] != S_IDLE && !ch_enable[i]) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = {CNT_W{1'b0}};
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (arm && ch_enable[i]) begin
              state_d[i] = S_WAIT;
              cnt_d[i]   = {CNT_W{1'b0}};
            end else begin
              state_d[i] = S_IDLE;
            end
          end
          S_WAIT: begin
            if (gate_in[i]) begin
              state_d[i] = S_ON;
              cnt_d[i]   = {{(CNT_W-1){1'b0}}, 1'b1};
            end else if (cnt_q[i] >= timeout_val) begin
              state_d[i] = S_IDLE;
              cnt_d[i]   = {CNT_W{1'b0}};
              set_to[i]  = 1'b1;
            end else begin
              cnt_d[i] = sat_inc(cnt_q[i]);
            end
          end
          S_ON: begin
            if (!gate_in[i]) begin
              state_d[i] = S_IDLE;
              cnt_d[i]   = {CNT_W{1'b0}};
              set_sh[i]  = 1'b1;
            end else if (cnt_q[i] >= min_len_val) begin
              state_d[i] = S_OK;
            end else begin
              cnt_d[i] = sat_inc(cnt_q[i]);
            end
          end
          S_OK: begin
            if (!gate_in[i]) begin
              state_d[i] = S_IDLE;
              cnt_d[i]   = {CNT_W{1'b0}};
            end else begin
              state_d[i] = S_OK;
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = {CNT_W{1'b0}};
          end
        endcase
      end
    end
    // A set on the same edge as clear must survive.
    err_to_d = (err_to_q & ~{N_CH{clear}}) | set_to;
    err_sh_d = (err_sh_q & ~{N_CH{clear}}) | set_sh;
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      gate_active[i] = (state_q[i] == S_ON) || (state_q[i] == S_OK);
      gate_valid[i]  = (state_q[i] == S_OK);
      busy           = busy | (state_q[i] != S_IDLE);
    end
    err_timeout = err_to_q;
    err_short   = err_sh_q;
  end

endmodule

// File: doc/gate_timing_ctrl.md
Name: gate_timing_ctrl

Overview:
Per-channel gate sequencing and supervision controller for the BLM gate inputs. It sits directly behind the gate deglitchers and runs one small FSM per channel. On an arm pulse, each enabled channel waits for its deglitched gate to rise within a programmable timeout. It then checks that the gate stays high for a programmable minimum length. It reports active/valid status and sticky timeout/short-gate error flags to the register interface.

Parameters:
N_CH, 12, number of gate channels (1..32)
CNT_W, 16, width of the cycle counters and of the timeout/min-length values

Ports:
clock  in  1  system clock
reset  in  1  reset, asynchronous, active-high
gate_in  in  N_CH  deglitched gate levels, synchronous to clock
ch_enable  in  N_CH  per-channel enable
arm  in  1  single-cycle pulse that starts a gate cycle on all idle enabled channels
clear  in  1  single-cycle pulse that clears all error flags
timeout_val  in  CNT_W  max wait for gate rise, in clock cycles
min_len_val  in  CNT_W  minimum gate-high length, in clock cycles
gate_active  out  N_CH  channel is in GATE_ON or GATE_OK
gate_valid  out  N_CH  channel is in GATE_OK (minimum length reached)
err_timeout  out  N_CH  sticky: gate did not rise in time
err_short  out  N_CH  sticky: gate fell before the minimum length
busy  out  1  OR over all channels not in IDLE

Behaviour:
- Reset: all channels go to IDLE with cnt=0. gate_active, gate_valid, err_timeout, err_short and busy are all 0.
- Each channel has a 2-bit state register and a CNT_W counter. Outputs decode directly from the registered state, with no combinational path from the inputs.
- Config values (timeout_val, min_len_val) are sampled every cycle. Software changes them only while busy=0; behaviour is undefined if they change mid-cycle.
- IDLE:
  - arm=1 and ch_enable[i]=1 -> WAIT_RISE, cnt<=0.
  - Otherwise stay in IDLE.
- WAIT_RISE:
  - gate_in[i]=1 -> GATE_ON, cnt<=1. Gate rise has priority over timeout.
  - Else if cnt>=timeout_val -> IDLE and set err_timeout[i].
  - Else cnt<=cnt+1.
  - Net effect: the gate is accepted if sampled high on any of the first timeout_val+1 edges after entry.
- GATE_ON:
  - gate_in[i]=0 -> IDLE and set err_short[i].
  - Else if cnt>=min_len_val -> GATE_OK.
  - Else cnt<=cnt+1.
  - gate_valid rises max(min_len_val,1) cycles after gate_active rises.
- GATE_OK:
  - gate_in[i]=0 -> IDLE, with no error.
  - Otherwise hold. gate_active and gate_valid both stay 1.
- arm in a non-IDLE state: ignored; no restart.
- ch_enable[i]=0 in any non-IDLE state: -> IDLE on the next edge with no error flag; this has priority over all other transitions.
- Counter saturates at all-ones and never wraps.
- Error flags are sticky and clear only on the clear pulse. If clear and an error set happen on the same edge, the set wins. Clear does not affect the FSMs.
- Latency: a gate_in rise sampled at edge k in WAIT_RISE gives gate_active=1 after edge k.
- Async reset asserted mid-operation returns every channel to IDLE immediately and clears all flags.
- Channels are fully independent. The only shared resources are arm, clear, the config values and the busy OR.

Test Plan:
- Timeout: timeout_val=5, ch_enable=1, arm at edge 0, gate held low -> err_timeout[0]=1 after edge 6, busy=0 after edge 6, gate_active never set.
- Good gate: timeout_val=5, min_len_val=4, arm at edge 0, gate high from edge 3 for 20 cycles -> gate_active=1 after edge 3, gate_valid=1 after edge 7, both drop after the edge sampling gate=0, no error flags.
- Short gate: min_len_val=10, gate high for 4 cycles after arm -> err_short=1 when gate falls, gate_valid never 1; clear pulse -> err_short=0 next cycle.
- Boundaries: timeout_val=0 with gate already high at the first sample -> accepted, no timeout. timeout_val=0 with gate low -> err_timeout one edge after entry. min_len_val=0 -> behaves as 1.
- Simultaneous events: an error and clear on the same edge -> flag stays 1. arm during GATE_ON -> ignored. ch_enable dropped in GATE_ON -> IDLE with no error flag.
- Multi-channel/reset: N_CH=12, channels 0..5 enabled with staggered gates -> independent results, channels 6..11 stay IDLE; async reset mid-GATE_ON -> all outputs 0 immediately.
